// File: rtl/key_counter_pkg.sv
// General: constants and elaboration-time helpers shared by the key and display blocks.
package General;
   localparam logic KeyReleased = 1'b1;
   function automatic int clog2(input int value);
      int r;
      r = 0;
      while ((1 << r) < value) r++;
      return (r < 1) ? 1 : r;
   endfunction
   function automatic int debounce_cycles(input int debounce_time_ns, input int clock_period_ns);
      return debounce_time_ns / clock_period_ns;
   endfunction
endpackage

// File: rtl/key_debouncer.sv
// key_debouncer: synchronizes an active-low raw key, debounces it and pulses Press once per press.
module key_debouncer
   import General::*;
#(
   parameter int Cycles = 5
) (
   input  logic Clock,
   input  logic Reset,
   input  logic Key,
   output logic Press
);
   localparam int W = clog2(Cycles);
   logic [1:0] sync;
   logic stable;
   logic [W-1:0] count;
   logic settled;
   assign settled = count == W'(Cycles - 1);
   always_ff @(posedge Clock) begin
      if (Reset) begin
         sync <= {2{KeyReleased}};
         stable <= KeyReleased;
         count <= '0;
         Press <= 1'b0;
      end else begin
         sync <= {sync[0], Key};
         Press <= 1'b0;
         if (sync[1] == stable) begin
            count <= '0;
         end else if (settled) begin
            // A flip away from released is always a press; releases stay silent.
            stable <= sync[1];
            count <= '0;
            Press <= sync[1] != KeyReleased;
         end else begin
            count <= count + W'(1);
         end
      end
   end
endmodule

// File: rtl/key_counter.sv
// key_counter: debounced up/down/clear counter feeding the seven-segment display driver.
module key_counter
   import General::*;
#(
   parameter int    Size            = 4,
   parameter string Signed          = "No",
   parameter int    ClockPeriod_ns  = 20,
   parameter int    DebounceTime_ns = 10_000_000
) (
   input  logic            Clock,
   input  logic            Reset,
   input  logic            KeyUp,
   input  logic            KeyDown,
   input  logic            KeyClear,
   output logic [Size-1:0] Data,
   output logic            Overflow,
   output logic            Underflow
);
   localparam int DebounceCycles = debounce_cycles(DebounceTime_ns, ClockPeriod_ns);
   logic press_up, press_down, press_clear;
   logic [Size-1:0] inc, dec;
   logic inc_wrap, dec_wrap;
   key_debouncer #(.Cycles(DebounceCycles)) u_up (.Clock(Clock), .Reset(Reset), .Key(KeyUp), .Press(press_up));
   key_debouncer #(.Cycles(DebounceCycles)) u_down (.Clock(Clock), .Reset(Reset), .Key(KeyDown), .Press(press_down));
   key_debouncer #(.Cycles(DebounceCycles)) u_clear (.Clock(Clock), .Reset(Reset), .Key(KeyClear), .Press(press_clear));
   generate
      if (Signed == "Yes") begin : g_signed
         localparam logic [Size-2:0] Max = '1;
         localparam logic [Size-2:0] One = 1;
         logic neg;
         logic [Size-2:0] mag;
         // Sign-magnitude: stepping toward zero from -1 lands on +0, never -0.
         always_comb begin
            neg = Data[Size-1];
            mag = Data[Size-2:0];
            inc_wrap = !neg && mag == Max;
            dec_wrap = neg && mag == Max;
            inc = neg ? (mag == One ? '0 : {1'b1, mag - One}) : (inc_wrap ? {1'b1, Max} : {1'b0, mag + One});
            dec = neg ? (dec_wrap ? {1'b0, Max} : {1'b1, mag + One}) : (mag == '0 ? {1'b1, One} : {1'b0, mag - One});
         end
      end else begin : g_unsigned
         localparam logic [Size-1:0] One = 1;
         always_comb begin
            inc = Data + One;
            dec = Data - One;
            inc_wrap = Data == '1;
            dec_wrap = Data == '0;
         end
      end
   endgenerate
   always_ff @(posedge Clock) begin
      if (Reset) begin
         Data <= '0;
         Overflow <= 1'b0;
         Underflow <= 1'b0;
      end else begin
         Data <= press_clear ? '0 : (press_up == press_down) ? Data : press_up ? inc : dec;
         Overflow <= !press_clear && press_up && !press_down && inc_wrap;
         Underflow <= !press_clear && press_down && !press_up && dec_wrap;
      end
   end
endmodule

// File: doc/key_counter.md
# key_counter

Debounced push-button up/down counter that produces the binary value shown on the seven-segment display. Sits directly upstream of the segment display driver. Its `Data` output connects straight to the driver's `Data` input, using the same `Size` and `Signed` parameter values. In signed mode, `Data` is in sign-magnitude form: MSB is the sign, lower bits are the magnitude. This is the encoding the display driver expects.

## Interface
- `Size`, 4: width of `Data` in bits; must be ≥ 2.
- `Signed`, "No": "No" gives unsigned 0..2^Size−1; "Yes" gives sign-magnitude −(2^(Size−1)−1)..+(2^(Size−1)−1).
- `ClockPeriod_ns`, 20: period of `Clock`.
- `DebounceTime_ns`, 10_000_000: required stable time of a key. Derived `DebounceCycles = DebounceTime_ns / ClockPeriod_ns`, which must be ≥ 2.

- `Clock` in 1: system clock; every register is on the rising edge.
- `Reset` in 1: synchronous, active-high reset.
- `KeyUp` in 1: raw button input, asynchronous, active-low (0 = pressed).
- `KeyDown` in 1: raw button input, asynchronous, active-low.
- `KeyClear` in 1: raw button input, asynchronous, active-low.
- `Data` out `Size`: current count; goes to the display driver.
- `Overflow` out 1: one-cycle pulse when an increment wraps.
- `Underflow` out 1: one-cycle pulse when a decrement wraps.

## Operation
- **Key path.** Each key goes through a 2-flop synchronizer, then a debouncer.
  - The debouncer holds a `Stable` level, reset to released (1), and a mismatch counter.
  - Each cycle where the synchronized level ≠ `Stable`: counter increments. Any cycle where they are equal: counter clears to 0, so bounce restarts the count.
  - When the counter reaches `DebounceCycles` consecutive mismatches: `Stable` takes the synchronized level and the counter clears.
  - `Press` is a one-cycle pulse on each `Stable` 1→0 transition. A release produces no event.
- **Count update, per cycle, by priority:**
  1. `PressClear` → `Data` ← 0. Up/down presses in the same cycle are ignored.
  2. `PressUp` and `PressDown` together → no change.
  3. `PressUp` alone → increment.
  4. `PressDown` alone → decrement.
- **Unsigned arithmetic.** Modulo 2^Size.
  - Max + 1 → 0, with `Overflow`.
  - 0 − 1 → max, with `Underflow`.
- **Signed arithmetic** (sign-magnitude).
  - Increment: negative → magnitude − 1; non-negative → magnitude + 1.
  - Decrement is symmetric.
  - Negative zero is never produced: −1 + 1 gives `Data` = 0 with sign bit 0.
  - +max + 1 → −max, with `Overflow`.
  - −max − 1 → +max, with `Underflow`.
- **Pulses.** `Overflow` and `Underflow` are registered and high for exactly the cycle after the wrapping edge. They are never both high.
- **Reset values.** `Data` = 0, `Overflow` = 0, `Underflow` = 0, all `Stable` = 1, debounce counters = 0, synchronizers = 1.
- **Reset mid-operation.** Reset overrides everything in the same edge. A key still held through reset deassertion is seen as a new press once `DebounceCycles` have elapsed, and counts once.

## Timing
- Let edge k be the first edge at which a raw key is sampled low, with the key held low from then on.
  - The synchronized level is valid after edge k+1.
  - Mismatches are counted on edges k+2 … k+1+`DebounceCycles`; `Stable` flips on the last of these.
  - `Press` is high in the following cycle.
  - `Data` changes on edge k+2+`DebounceCycles`.
  - `Overflow`/`Underflow` are high in the cycle after that edge.
- A glitch shorter than `DebounceCycles` cycles produces no event.
- Holding a key produces exactly one event; there is no auto-repeat.
- Minimum spacing between two counted presses of the same key is 2·`DebounceCycles` cycles (release, then press).
- Throughput: at most one `Data` update per cycle. Keys are fully independent.

## Structure
- Shared package `General`:
  - add constant `KeyReleased` = 1'b1;
  - add function `debounce_cycles(DebounceTime_ns, ClockPeriod_ns)`;
  - counter widths use the existing `General::clog2`.
- Sub-module `key_debouncer`, instantiated three times. Parameter `Cycles`; ports `Clock`, `Reset`, `Key`, `Press`. It contains the synchronizer, mismatch counter, `Stable` register and press-edge detector.
- The top level holds the priority logic, the unsigned and sign-magnitude arithmetic (selected by a `Signed` generate branch), and the `Overflow`/`Underflow` registers.

## Test plan
Bench parameters: `DebounceTime_ns` = 100, `ClockPeriod_ns` = 20, so `DebounceCycles` = 5.

- **Debounce and latency.** `KeyUp` low from edge k, `Size` = 4, unsigned → `Data` goes 0→1 exactly at edge k+7 and stays 1 while the key is held. A 4-cycle low glitch → `Data` unchanged.
- **Bounce.** `KeyUp` toggles low/high every 2 cycles for 20 cycles, then stays low → exactly one increment, 5 edges after the final settle sample plus 2.
- **Unsigned wrap.** 15 presses of Up → `Data` = 15. One more press → `Data` = 0 and `Overflow` high for 1 cycle. Then one Down press → `Data` = 15 and `Underflow` pulses.
- **Signed.** `Signed` = "Yes", `Size` = 4.
  - Down from 0 → `Data` = 4'b1001 (−1).
  - Up → 4'b0000, never 4'b1000.
  - 7 Ups from 0 → 4'b0111; one more Up → 4'b1111 (−7) with `Overflow`.
- **Simultaneous keys.** Up and Down debounced on the same edge → no change and no pulses. Clear together with Up at `Data` = 9 → `Data` = 0.
- **Reset.** `Reset` asserted at `Data` = 5, mid-debounce → next edge gives `Data` = 0 and pulses 0. A key held through reset release → exactly one increment, 7 edges after release.
